ex_seq_alu: RTL and testbench
=============================

Name: ex_seq_alu

Overview:
- Execute-stage unit that consumes the decoded execute controls: `alu_op`, `branch_alu_op`, `in1`, `in2`, and the raw register operands.
- Produces the ALU result `z` and the branch-taken decision.
- Shifts are iterative, taking multiple cycles; all other ops take one cycle.
- Sits between the execute-control decode and the EX/MEM pipeline register, with valid/ready handshakes on both sides so the pipeline stalls on long shifts.

Parameters:
- `SHIFT_STEP`, default 1: bits shifted per cycle in the SHIFT state. Legal values are 1, 2, 4 and 8.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  kill any in-flight op (pipeline flush on taken branch or trap)
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept a request this cycle
- `alu_op`  in  4  ALU operation code (shared constants)
- `branch_alu_op`  in  3  branch condition code (shared constants)
- `in1`  in  32  ALU operand 1 (pc, rs1 or csr value, as selected upstream)
- `in2`  in  32  ALU operand 2 (imm, rs2 or rs1, as selected upstream)
- `data1`  in  32  rs1 value, used for the branch compare
- `data2`  in  32  rs2 value, used for the branch compare
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts the result
- `z`  out  32  ALU result
- `taken`  out  1  branch/jump taken

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE; `out_valid`=0, `z`=0, `taken`=0, shift count=0. `in_ready`=1 in the first cycle after reset.
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=0.
  - DONE: `out_valid`=1; `in_ready`=`out_ready`.
- Accept occurs when `in_valid` & `in_ready` & !`flush`. On accept, all inputs are captured in registers; the inputs are not sampled again.
- Non-shift ops: result registered on the accept edge; go to DONE. `out_valid` is high the cycle after accept (latency 1).
- Shift ops (SLL, SRL, SRA):
  - n = `in2[4:0]`.
  - If n=0: go to DONE with `z`=`in1` (latency 1).
  - Otherwise: accumulator=`in1`, count=n, go to SHIFT.
  - Each SHIFT cycle shifts by min(`SHIFT_STEP`, count) and subtracts the same amount from count.
  - When count reaches 0, go to DONE.
  - Latency is 1+ceil(n/`SHIFT_STEP`). SRA fills with the sign bit of the original `in1`.
- DONE handling:
  - If `out_ready`=0: hold `z`, `taken` and `out_valid` stable.
  - If `out_ready`=1 and a new accept occurs: load the new op (back-to-back, no bubble).
  - If `out_ready`=1 and no accept: go to IDLE, `out_valid`=0.
- ALU ops:
  - ADD: `in1`+`in2`, mod 2^32.
  - SUB: `in1`-`in2`.
  - SLT / SLTU: {31'b0, signed or unsigned `in1`<`in2`}.
  - XOR, OR, AND: bitwise.
  - CP_IN2: `in2`.
  - JALR: (`in1`+`in2`) & ~32'h1.
  - CSRRC: `in1` & ~`in2`.
  - X_ALU_OP or any undefined code: 0.
- Branch ops (compare `data1` vs `data2`; never `in1`/`in2`):
  - BEQ, BNE.
  - BLT, BGE: signed.
  - BLTU, BGEU: unsigned.
  - JUMP → 1.
  - NO_JUMP or any undefined code → 0.
  - `taken` is registered alongside `z`, so it has the same latency.
- Flush: has priority over everything except `rst`. Next state is IDLE, with `out_valid`=0 the next cycle, an in-progress shift abandoned, and no accept in the flush cycle (`in_ready` is forced to 0 while `flush`=1).
- `rst` mid-shift: identical to the reset values above.
- `out_valid` never rises without a prior accept; exactly one result is produced per accept unless that accept is flushed.

Decomposition:
- `constants/alu_op.v` (shared) defines the `alu_op` codes:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111
  - SUB 1000, CP_IN2 1001, JALR 1010, CSRRC 1011, SRA 1101, X_ALU_OP 1111
- `constants/branch_alu_op.v` (shared) defines the `branch_alu_op` codes:
  - BEQ 000, BNE 001, JUMP 010, NO_JUMP 011
  - BLT 100, BGE 101, BLTU 110, BGEU 111
- State encodings are local to the module.
- One sub-module, `branch_cmp`: combinational compare of `data1`/`data2` against `branch_alu_op`, returning `taken`. It is reusable by a future early-branch-resolve stage.

Test Plan:
- ADD `in1`=32'hFFFF_FFFF, `in2`=1, `out_ready`=1 → `out_valid` 1 cycle after accept, `z`=0. SUB 5-7 → `z`=32'hFFFF_FFFE. SLT/SLTU with `in1`=32'h8000_0000, `in2`=1 → `z`=1 and 0 respectively.
- SRA `in1`=32'h8000_0010, `in2`=4, `SHIFT_STEP`=1 → `in_ready`=0 for 4 cycles, `out_valid` at accept+5, `z`=32'hF800_0001. Repeat with `SHIFT_STEP`=4 → `out_valid` at accept+2. SLL with `in2`=0 → latency 1, `z`=`in1`.
- Branch BLT `data1`=-1, `data2`=0 → `taken`=1; BLTU with the same operands → `taken`=0; JUMP → 1; NO_JUMP → 0. JALR `in1`=32'h1001, `in2`=2 → `z`=32'h1002.
- Backpressure: `out_ready`=0 for 3 cycles in DONE → `z`, `taken` and `out_valid` held and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 → result consumed and the new op accepted in the same cycle; the next result arrives one cycle later.
- `flush` asserted on the 2nd cycle of a 10-bit SRL → IDLE next cycle, `out_valid` never rises for that op. Flush with `in_valid`=1 in IDLE → no accept.
- `rst` asserted mid-shift and in DONE → next cycle `out_valid`=0, `z`=0, `taken`=0, `in_ready`=1.

Source files
------------

// File: rtl/ex_seq_alu_pkg.sv
// Shared execute-stage constants and the single-cycle ALU function.
// The ALU and branch encodings match the decode stage's constant tables.
package ex_seq_alu_pkg;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SLL    = 4'b0001;
   localparam logic [3:0] ALU_SLT    = 4'b0010;
   localparam logic [3:0] ALU_SLTU   = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_SRL    = 4'b0101;
   localparam logic [3:0] ALU_OR     = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_SUB    = 4'b1000;
   localparam logic [3:0] ALU_CP_IN2 = 4'b1001;
   localparam logic [3:0] ALU_JALR   = 4'b1010;
   localparam logic [3:0] ALU_CSRRC  = 4'b1011;
   localparam logic [3:0] ALU_SRA    = 4'b1101;
   localparam logic [3:0] ALU_X_OP   = 4'b1111;

   localparam logic [2:0] BR_BEQ     = 3'b000;
   localparam logic [2:0] BR_BNE     = 3'b001;
   localparam logic [2:0] BR_JUMP    = 3'b010;
   localparam logic [2:0] BR_NO_JUMP = 3'b011;
   localparam logic [2:0] BR_BLT     = 3'b100;
   localparam logic [2:0] BR_BGE     = 3'b101;
   localparam logic [2:0] BR_BLTU    = 3'b110;
   localparam logic [2:0] BR_BGEU    = 3'b111;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

   // Shift codes return the operand unchanged: a zero-distance shift completes here.
   function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      case (op)
         ALU_ADD:    r = a + b;
         ALU_SUB:    r = a - b;
         ALU_SLT:    r = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU:   r = {31'b0, a < b};
         ALU_XOR:    r = a ^ b;
         ALU_OR:     r = a | b;
         ALU_AND:    r = a & b;
         ALU_CP_IN2: r = b;
         ALU_JALR:   r = (a + b) & ~32'h1;
         ALU_CSRRC:  r = a & ~b;
         ALU_SLL, ALU_SRL, ALU_SRA: r = a;
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_seq_alu_branch_cmp.sv
// Combinational branch condition evaluation on the raw register operands.
// Kept standalone so an early branch-resolve stage can reuse it.
module ex_seq_alu_branch_cmp
   import ex_seq_alu_pkg::*;
(
   input  logic [2:0]  branch_alu_op,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (branch_alu_op)
         BR_BEQ:     taken = (data1 == data2);
         BR_BNE:     taken = (data1 != data2);
         BR_BLT:     taken = ($signed(data1) <  $signed(data2));
         BR_BGE:     taken = ($signed(data1) >= $signed(data2));
         BR_BLTU:    taken = (data1 <  data2);
         BR_BGEU:    taken = (data1 >= data2);
         BR_JUMP:    taken = 1'b1;
         default:    taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_seq_alu.sv
// Execute-stage ALU with iterative shifter and valid/ready handshakes on both sides.
// Shifts walk SHIFT_STEP bits per cycle; every other op finishes on the accept edge.
module ex_seq_alu
   import ex_seq_alu_pkg::*;
#(
   parameter int SHIFT_STEP = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  alu_op,
   input  logic [2:0]  branch_alu_op,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z,
   output logic        taken
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   state_t      state, state_n;
   logic [31:0] z_q;
   logic        taken_q;
   logic [4:0]  count;
   logic [3:0]  op_q;
   logic        accept;
   logic        start_shift;
   logic        br_taken;
   logic [4:0]  step;
   logic [31:0] shifted;

   ex_seq_alu_branch_cmp u_branch_cmp (
      .branch_alu_op (branch_alu_op),
      .data1         (data1),
      .data2         (data2),
      .taken         (br_taken)
   );

   // A request is taken when idle, or when the held result leaves this same cycle.
   assign in_ready    = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
   assign accept      = in_valid && in_ready;
   assign start_shift = is_shift(alu_op) && (in2[4:0] != 5'd0);
   assign step        = (count < STEP) ? count : STEP;
   assign out_valid   = (state == ST_DONE);
   assign z           = z_q;
   assign taken       = taken_q;

   always_comb begin
      shifted = z_q;
      case (op_q)
         ALU_SLL: shifted = z_q << step;
         ALU_SRL: shifted = z_q >> step;
         ALU_SRA: shifted = 32'($signed(z_q) >>> step);
         default: shifted = z_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = ST_IDLE;
      end else if (accept) begin
         state_n = start_shift ? ST_SHIFT : ST_DONE;
      end else begin
         case (state)
            ST_SHIFT: if (count == step) state_n = ST_DONE;
            ST_DONE:  if (out_ready)     state_n = ST_IDLE;
            default:  state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_q     <= '0;
         taken_q <= 1'b0;
         count   <= '0;
         op_q    <= ALU_ADD;
      end else if (accept) begin
         op_q    <= alu_op;
         taken_q <= br_taken;
         if (start_shift) begin
            z_q   <= in1;
            count <= in2[4:0];
         end else begin
            z_q   <= alu_calc(alu_op, in1, in2);
            count <= '0;
         end
      end else if ((state == ST_SHIFT) && !flush) begin
         z_q   <= shifted;
         count <= count - step;
      end
   end

endmodule

// File: tb/tb_ex_seq_alu.sv
// Bench for ex_seq_alu: directed literal cases plus randomized traffic against
// a result/latency model; a second instance runs with a 4-bit shift step.
module tb_ex_seq_alu;

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SLL = 4'b0001, OP_SLT = 4'b0010,
                          OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_SRL = 4'b0101,
                          OP_OR = 4'b0110, OP_AND = 4'b0111, OP_SUB = 4'b1000,
                          OP_CP = 4'b1001, OP_JALR = 4'b1010, OP_CSRRC = 4'b1011,
                          OP_SRA = 4'b1101, OP_X = 4'b1111;
   localparam logic [2:0] B_BEQ = 3'b000, B_BNE = 3'b001, B_JUMP = 3'b010,
                          B_NOJ = 3'b011, B_BLT = 3'b100, B_BGE = 3'b101,
                          B_BLTU = 3'b110, B_BGEU = 3'b111;
   localparam int STEP_A = 1;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [3:0]  alu_op;
   logic [2:0]  branch_alu_op;
   logic [31:0] in1, in2, data1, data2;
   logic        in_ready, out_valid, taken;
   logic [31:0] z;

   logic        in_valid4, out_ready4, in_ready4, out_valid4, taken4;
   logic        flush4 = 1'b0;
   logic [3:0]  alu_op4;
   logic [2:0]  branch4 = 3'b011;
   logic [31:0] in1_4, in2_4, z4;
   logic [31:0] zero32 = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_seq_alu #(.SHIFT_STEP(STEP_A)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .branch_alu_op(branch_alu_op), .in1(in1), .in2(in2),
      .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .taken(taken)
   );

   ex_seq_alu #(.SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
      .alu_op(alu_op4), .branch_alu_op(branch4), .in1(in1_4), .in2(in2_4),
      .data1(zero32), .data2(zero32), .out_valid(out_valid4), .out_ready(out_ready4),
      .z(z4), .taken(taken4)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int n;
      n = int'(b % 32);
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_SLL:   return a << n;
         OP_SRL:   return a >> n;
         OP_SRA:   return 32'($signed(a) >>> n);
         OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         OP_XOR:   return a ^ b;
         OP_OR:    return a | b;
         OP_AND:   return a & b;
         OP_CP:    return b;
         OP_JALR:  return (a + b) & 32'hFFFF_FFFE;
         OP_CSRRC: return a & ~b;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] br, input logic [31:0] d1,
                                      input logic [31:0] d2);
      case (br)
         B_BEQ:  return d1 == d2;
         B_BNE:  return d1 != d2;
         B_BLT:  return $signed(d1) < $signed(d2);
         B_BGE:  return !($signed(d1) < $signed(d2));
         B_BLTU: return d1 < d2;
         B_BGEU: return !(d1 < d2);
         B_JUMP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Extra cycles spent shifting after the accept edge.
   function automatic int ref_extra(input logic [3:0] op, input logic [31:0] b, input int step);
      int n;
      n = int'(b % 32);
      if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && n != 0)
         return (n + step - 1) / step;
      return 0;
   endfunction

   logic [32:0] exp_q[$];
   bit          m_has = 1'b0;
   int          m_left = 0;
   bit          started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin : model_proc
      bit rdy;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_has = 1'b0;
            exp_q.delete();
            started = 1'b1;
         end else if (started) begin
            if (flush) begin
               m_has = 1'b0;
               exp_q.delete();
            end else begin
               rdy = !m_has || (m_left == 0 && out_ready);
               if (m_has) begin
                  if (m_left > 0) m_left--;
                  else if (out_ready) begin
                     m_has = 1'b0;
                     void'(exp_q.pop_front());
                  end
               end
               if (in_valid && rdy) begin
                  m_has  = 1'b1;
                  m_left = ref_extra(alu_op, in2, STEP_A);
                  exp_q.push_back({ref_taken(branch_alu_op, data1, data2),
                                   ref_alu(alu_op, in1, in2)});
               end
            end
         end
      end
   end

   initial begin : compare_proc
      bit ev;
      forever begin
         @(negedge clk);
         if (started) begin
            ev = m_has && (m_left == 0);
            chk("cyc_in_ready", {31'b0, in_ready},
                {31'b0, !flush && (!m_has || (m_left == 0 && out_ready))});
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, ev});
            if (ev && exp_q.size() > 0) begin
               chk("cyc_z", z, exp_q[0][31:0]);
               chk("cyc_taken", {31'b0, taken}, {31'b0, exp_q[0][32]});
            end
         end
      end
   end

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic run_op(input string name, input logic [3:0] op, input logic [2:0] br,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] ez, input logic et,
                         input int elat);
      int lat;
      bit ok;
      alu_op = op; branch_alu_op = br; in1 = a; in2 = b; data1 = d1; data2 = d2;
      in_valid = 1'b1; out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      chk({name, "_accept"}, {31'b0, ok}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in1 = $urandom; in2 = $urandom; data1 = $urandom; data2 = $urandom;
      alu_op = 4'($urandom_range(0, 15)); branch_alu_op = 3'($urandom_range(0, 7));
      ok = 1'b0; lat = 0;
      for (int i = 0; i < 50; i++) begin
         lat++;
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      chk({name, "_lat"}, lat, elat);
      chk({name, "_z"}, z, ez);
      chk({name, "_taken"}, {31'b0, taken}, {31'b0, et});
      @(posedge clk); #1;
   endtask

   task automatic run4(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ez, input int elat);
      int lat;
      bit ok;
      alu_op4 = op; in1_4 = a; in2_4 = b; in_valid4 = 1'b1; out_ready4 = 1'b1;
      @(negedge clk);
      chk({name, "_rdy"}, {31'b0, in_ready4}, 32'd1);
      @(posedge clk); #1;
      in_valid4 = 1'b0; in1_4 = $urandom; in2_4 = $urandom;
      ok = 1'b0; lat = 0;
      for (int i = 0; i < 50; i++) begin
         lat++;
         @(negedge clk);
         if (out_valid4) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      chk({name, "_lat"}, lat, elat);
      chk({name, "_z"}, z4, ez);
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main_proc
      bit seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = OP_ADD; branch_alu_op = B_NOJ; in1 = '0; in2 = '0; data1 = '0; data2 = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b1; alu_op4 = OP_ADD; in1_4 = '0; in2_4 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_z", z, 32'd0);
      chk("rst_taken", {31'b0, taken}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      run_op("add_wrap", OP_ADD,   B_NOJ,  32'hFFFF_FFFF, 32'd1, 0, 0, 32'h0, 1'b0, 1);
      run_op("sub",      OP_SUB,   B_NOJ,  32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1'b0, 1);
      run_op("slt",      OP_SLT,   B_NOJ,  32'h8000_0000, 32'd1, 0, 0, 32'd1, 1'b0, 1);
      run_op("sltu",     OP_SLTU,  B_NOJ,  32'h8000_0000, 32'd1, 0, 0, 32'd0, 1'b0, 1);
      run_op("sra4",     OP_SRA,   B_NOJ,  32'h8000_0010, 32'd4, 0, 0, 32'hF800_0001, 1'b0, 5);
      run_op("sll0",     OP_SLL,   B_NOJ,  32'h1234_5678, 32'd0, 0, 0, 32'h1234_5678, 1'b0, 1);
      run_op("srl32",    OP_SRL,   B_NOJ,  32'hCAFE_0001, 32'h20, 0, 0, 32'hCAFE_0001, 1'b0, 1);
      run_op("sll31",    OP_SLL,   B_NOJ,  32'd3, 32'd31, 0, 0, 32'h8000_0000, 1'b0, 32);
      run_op("blt",      OP_ADD,   B_BLT,  0, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1);
      run_op("bltu",     OP_ADD,   B_BLTU, 0, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);
      run_op("jump",     OP_ADD,   B_JUMP, 0, 0, 32'd1, 32'd2, 32'd0, 1'b1, 1);
      run_op("nojump",   OP_ADD,   B_NOJ,  0, 0, 32'd1, 32'd1, 32'd0, 1'b0, 1);
      run_op("beq",      OP_OR,    B_BEQ,  32'hF0, 32'h0F, 32'd9, 32'd9, 32'hFF, 1'b1, 1);
      run_op("jalr",     OP_JALR,  B_JUMP, 32'h1001, 32'd2, 0, 0, 32'h1002, 1'b1, 1);
      run_op("csrrc",    OP_CSRRC, B_NOJ,  32'hF0F0, 32'h00FF, 0, 0, 32'hF000, 1'b0, 1);
      run_op("xop",      OP_X,     B_NOJ,  32'h1234, 32'h1, 0, 0, 32'h0, 1'b0, 1);
      run_op("undef",    4'b1100,  3'b011, 32'h1234, 32'h1, 0, 0, 32'h0, 1'b0, 1);

      // backpressure in DONE, then back-to-back accept
      alu_op = OP_XOR; branch_alu_op = B_JUMP; in1 = 32'hA5A5_A5A5; in2 = 32'hFFFF_0000;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_z", z, 32'h5A5A_A5A5);
         chk("bp_taken", {31'b0, taken}, 32'd1);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      alu_op = OP_ADD; branch_alu_op = B_NOJ; in1 = 32'd3; in2 = 32'd4;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_z", z, 32'd7);
      chk("b2b_taken", {31'b0, taken}, 32'd0);
      @(posedge clk); #1;

      // flush on the second shift cycle of a 10-bit SRL
      alu_op = OP_SRL; branch_alu_op = B_JUMP; in1 = 32'hFFFF_FFFF; in2 = 32'd10;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("flush_shift_no_valid", {31'b0, seen}, 32'd0);
      flush = 1'b1; in_valid = 1'b1; alu_op = OP_ADD; in1 = 32'd1; in2 = 32'd1;
      @(negedge clk);
      chk("flush_idle_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle_no_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // reset mid-shift
      alu_op = OP_SRL; branch_alu_op = B_JUMP; in1 = 32'hFFFF_FFFF; in2 = 32'd10;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_shift_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_shift_z", z, 32'd0);
      chk("rst_shift_taken", {31'b0, taken}, 32'd0);
      chk("rst_shift_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // reset while holding a result in DONE
      alu_op = OP_ADD; branch_alu_op = B_JUMP; in1 = 32'd1; in2 = 32'd2;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_done_pre_z", z, 32'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_done_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_done_z", z, 32'd0);
      chk("rst_done_taken", {31'b0, taken}, 32'd0);
      chk("rst_done_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // four-bit step instance
      run4("s4_sra4",  OP_SRA, 32'h8000_0010, 32'd4,  32'hF800_0001, 2);
      run4("s4_srl10", OP_SRL, 32'hFFFF_FFFF, 32'd10, 32'h003F_FFFF, 4);
      run4("s4_sll31", OP_SLL, 32'd1,         32'd31, 32'h8000_0000, 9);
      run4("s4_sll0",  OP_SLL, 32'h0BAD_F00D, 32'd0,  32'h0BAD_F00D, 1);

      // randomized traffic checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         in_valid      = ($urandom_range(0, 2) != 0);
         out_ready     = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 29) == 0);
         rst           = ($urandom_range(0, 399) == 0);
         alu_op        = 4'($urandom_range(0, 15));
         branch_alu_op = 3'($urandom_range(0, 7));
         in1           = $urandom;
         in2           = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         data1         = $urandom;
         data2         = ($urandom_range(0, 3) == 0) ? data1 : $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; rst = 1'b0;
      repeat (40) begin @(posedge clk); #1; end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
